div_unit: RTL

//  Multi-cycle iterative divider; the responder on the EX-stage divide interface of the pipelined MIPS datapath.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared state type, default operand width and result field layout for the iterative divider.
package div_pkg;
  localparam int DIV_W    = 32;
  localparam int LO_FIELD = 0;   // quotient occupies the low WIDTH bits of the result
  localparam int HI_FIELD = 1;   // remainder occupies the high WIDTH bits of the result

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, trial-subtract the divisor,
// and record the quotient bit in the vacated LSB.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, quot_i[WIDTH-1]};
  // The partial remainder stays below the divisor, so bit WIDTH of diff is a clean borrow flag.
  assign diff    = shifted - {1'b0, divisor_i};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_o  = {quot_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) returning {remainder, quotient}; stalls the pipeline while busy.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               stall_div,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               a_neg, b_neg, accept, early_out;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_rem, step_quot, rem_fix, quot_fix;
  logic [2*WIDTH-1:0] final_res;

  assign a_neg  = signed_i & a_i[WIDTH-1];
  assign b_neg  = signed_i & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign accept = (state_q == IDLE) & start_i & ~annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (b_i != '0) && (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // Sign fix-up is applied on the way out so the iteration only ever sees magnitudes.
  assign quot_fix = quot_neg_q ? -quot_q : quot_q;
  assign rem_fix  = rem_neg_q  ? -rem_q  : rem_q;
  assign final_res[HI_FIELD*WIDTH +: WIDTH] = rem_fix;
  assign final_res[LO_FIELD*WIDTH +: WIDTH] = quot_fix;

  assign stall_div = accept | (state_q == BUSY);
  assign ready_o   = (state_q == DONE) & ~annul_i;
  assign result_o  = ready_o ? final_res : result_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          divisor_d  = b_mag;
          count_d    = CW'(WIDTH - 1);
          quot_neg_d = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          if (b_i == '0) begin
            // Divide by zero bypasses fix-up: raw dividend and all-ones quotient.
            rem_d      = a_i;
            quot_d     = '1;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            state_d    = DONE;
          end else if (early_out) begin
            rem_d   = a_mag;
            quot_d  = '0;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quot_d  = a_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!annul_i) begin
          result_d = final_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
    end
  end
endmodule
